// File: rtl/float_adder_pipe_norm_if.sv
// Handshake and data bundle between the FP adder calculation stage, this
// normalize/round/pack block, and the writeback consumer. FLOAT_NORM_FLAGS_EN adds s_flags.
interface float_adder_pipe_norm_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  c_rm;
  logic        c_sign;
  logic [7:0]  c_exp;
  logic [27:0] c_frac;
  logic        c_inf_nan;
  logic [22:0] c_inf_nan_frac;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] s;
`ifdef FLOAT_NORM_FLAGS_EN
  logic [2:0]  s_flags;
`endif

  modport master (
    output in_valid, c_rm, c_sign, c_exp, c_frac, c_inf_nan, c_inf_nan_frac, out_ready,
`ifdef FLOAT_NORM_FLAGS_EN
    input  s_flags,
`endif
    input  in_ready, out_valid, s
  );

  modport slave (
    input  in_valid, c_rm, c_sign, c_exp, c_frac, c_inf_nan, c_inf_nan_frac, out_ready,
`ifdef FLOAT_NORM_FLAGS_EN
    output s_flags,
`endif
    output in_ready, out_valid, s
  );
endinterface

// File: rtl/float_adder_pipe_norm.sv
// Two-stage normalize (N1) and round/pack (N2) tail of the binary32 FP adder.
// Optional macro FLOAT_NORM_FLAGS_EN adds the {overflow, underflow, inexact} flags output.
module float_adder_pipe_norm (
  input  logic                   clk,
  input  logic                   clrn,
  float_adder_pipe_norm_if.slave io
);

  logic        w_stall;
  logic [4:0]  w_lz;
  logic [8:0]  w_n1_exp;
  logic [26:0] w_n1_frac;

  logic        r_n1_valid;
  logic [1:0]  r_n1_rm;
  logic        r_n1_sign;
  logic [8:0]  r_n1_exp;
  logic [26:0] r_n1_frac;
  logic        r_n1_inf_nan;
  logic [22:0] r_n1_inf_nan_frac;

  logic        r_out_valid;
  logic [31:0] r_s;

  assign w_stall     = r_out_valid & ~io.out_ready;
  assign io.in_ready = ~w_stall;
  assign io.out_valid = r_out_valid;
  assign io.s        = r_s;

  // Highest set bit wins, so the last assignment in ascending order gives the leading-zero count.
  always_comb begin
    w_lz = 5'd0;
    for (int i = 0; i < 27; i++) begin
      if (io.c_frac[i]) w_lz = 5'(26 - i);
    end
  end

  always_comb begin
    w_n1_exp  = {1'b0, io.c_exp};
    w_n1_frac = io.c_frac[26:0];
    if (io.c_frac[27]) begin
      w_n1_frac = {io.c_frac[27:2], |io.c_frac[1:0]};
      w_n1_exp  = {1'b0, io.c_exp} + 9'd1;
    end else if (io.c_frac[26]) begin
      if (io.c_exp == 8'd0) w_n1_exp = 9'd1;
    end else if (io.c_frac == 28'd0) begin
      w_n1_exp = 9'd0;
    end else if (io.c_exp == 8'd0) begin
      w_n1_exp = 9'd0;
    end else if ({1'b0, io.c_exp} > {4'b0, w_lz}) begin
      w_n1_frac = io.c_frac[26:0] << w_lz;
      w_n1_exp  = {1'b0, io.c_exp} - {4'b0, w_lz};
    end else begin
      // Exponent runs out before the hidden bit reaches [26]: settle as a denormal.
      w_n1_frac = io.c_frac[26:0] << (io.c_exp - 8'd1);
      w_n1_exp  = 9'd0;
    end
  end

  logic [23:0] w_m;
  logic        w_grs;
  logic        w_inc;
  logic [24:0] w_sum;
  logic [23:0] w_rnd_m;
  logic [8:0]  w_rnd_e;
  logic        w_ovf;
  logic        w_use_inf;
  logic [31:0] w_s;

  assign w_m   = r_n1_frac[26:3];
  assign w_grs = |r_n1_frac[2:0];

  always_comb begin
    w_inc = 1'b0;
    unique case (r_n1_rm)
      2'b00: w_inc = r_n1_frac[2] & (r_n1_frac[1] | r_n1_frac[0] | w_m[0]);
      2'b01: w_inc = r_n1_sign & w_grs;
      2'b10: w_inc = ~r_n1_sign & w_grs;
      2'b11: w_inc = 1'b0;
    endcase
  end

  assign w_sum = {1'b0, w_m} + {24'b0, w_inc};

  always_comb begin
    w_rnd_m = w_sum[24] ? 24'h800000 : w_sum[23:0];
    w_rnd_e = r_n1_exp + {8'b0, w_sum[24]};
    if (w_rnd_e == 9'd0 && w_rnd_m[23]) w_rnd_e = 9'd1;
  end

  assign w_ovf     = (w_rnd_e >= 9'd255);
  assign w_use_inf = (r_n1_rm == 2'b00) |
                     ((r_n1_rm == 2'b01) &  r_n1_sign) |
                     ((r_n1_rm == 2'b10) & ~r_n1_sign);

  always_comb begin
    if (r_n1_inf_nan)
      w_s = {r_n1_sign, 8'hFF, r_n1_inf_nan_frac};
    else if (w_ovf)
      w_s = w_use_inf ? {r_n1_sign, 8'hFF, 23'd0} : {r_n1_sign, 8'hFE, 23'h7FFFFF};
    else
      w_s = {r_n1_sign, w_rnd_e[7:0], w_rnd_m[22:0]};
  end

`ifdef FLOAT_NORM_FLAGS_EN
  logic       w_inexact;
  logic       w_unf;
  logic [2:0] w_flags;
  logic [2:0] r_s_flags;

  assign w_inexact  = w_grs | w_ovf;
  assign w_unf      = ~w_ovf & (w_rnd_e == 9'd0) & w_inexact;
  assign w_flags    = r_n1_inf_nan ? 3'b000 : {w_ovf, w_unf, w_inexact};
  assign io.s_flags = r_s_flags;

  always_ff @(posedge clk) begin
    if (!clrn)
      r_s_flags <= 3'b000;
    else if (!w_stall && r_n1_valid)
      r_s_flags <= w_flags;
  end
`endif

  always_ff @(posedge clk) begin
    if (!clrn) begin
      r_n1_valid        <= 1'b0;
      r_n1_rm           <= 2'b00;
      r_n1_sign         <= 1'b0;
      r_n1_exp          <= 9'd0;
      r_n1_frac         <= 27'd0;
      r_n1_inf_nan      <= 1'b0;
      r_n1_inf_nan_frac <= 23'd0;
      r_out_valid       <= 1'b0;
      r_s               <= 32'd0;
    end else if (!w_stall) begin
      r_n1_valid <= io.in_valid;
      if (io.in_valid) begin
        r_n1_rm           <= io.c_rm;
        r_n1_sign         <= io.c_sign;
        r_n1_exp          <= w_n1_exp;
        r_n1_frac         <= w_n1_frac;
        r_n1_inf_nan      <= io.c_inf_nan;
        r_n1_inf_nan_frac <= io.c_inf_nan_frac;
      end
      r_out_valid <= r_n1_valid;
      if (r_n1_valid) r_s <= w_s;
    end
  end

endmodule

// File: tb/tb_float_adder_pipe_norm.sv
// Directed-vector bench for float_adder_pipe_norm: datapath vectors, stall and reset behaviour.
module tb_float_adder_pipe_norm;
  logic clk;
  logic clrn;
  int   total = 0;
  int   bad   = 0;

  float_adder_pipe_norm_if fif ();

  float_adder_pipe_norm dut (
    .clk  (clk),
    .clrn (clrn),
    .io   (fif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // Presents one vector, waits for its result; lat counts edges from acceptance (99 = timeout).
  task automatic run_vec(input logic [1:0] rm, input logic sgn, input logic [7:0] e,
                         input logic [27:0] f, input logic inf, input logic [22:0] nf,
                         output logic [31:0] res, output int lat);
    fif.c_rm = rm; fif.c_sign = sgn; fif.c_exp = e; fif.c_frac = f;
    fif.c_inf_nan = inf; fif.c_inf_nan_frac = nf;
    fif.out_ready = 1'b1;
    fif.in_valid  = 1'b1;
    @(posedge clk); #1;
    fif.in_valid = 1'b0;
    lat = 1;
    res = 32'hxxxxxxxx;
    while (lat < 10 && fif.out_valid !== 1'b1) begin
      @(posedge clk); #1;
      lat++;
    end
    if (fif.out_valid === 1'b1) res = fif.s;
    else lat = 99;
  endtask

  task automatic idle(input int n);
    fif.in_valid = 1'b0;
    fif.out_ready = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    total++;
    if (fif.out_valid !== 1'b0) begin $display("FAIL reset_out_valid got=%b want=0", fif.out_valid); bad++; end
    total++;
    if (fif.s !== 32'h0) begin $display("FAIL reset_s got=%h want=00000000", fif.s); bad++; end
    total++;
    if (fif.in_ready !== 1'b1) begin $display("FAIL reset_in_ready got=%b want=1", fif.in_ready); bad++; end
    $display("reset: out_valid=%b s=%h in_ready=%b", fif.out_valid, fif.s, fif.in_ready);
  endtask

  task automatic test_basic;
    logic [31:0] r;
    int lat;
    run_vec(2'b00, 1'b0, 8'h7F, 28'h8000000, 1'b0, 23'd0, r, lat);
    $display("1.0+1.0: s=%h lat=%0d", r, lat);
    total++;
    if (r !== 32'h40000000) begin $display("FAIL one_plus_one s=%h want=40000000", r); bad++; end
    total++;
    if (lat != 2) begin $display("FAIL latency got=%0d want=2", lat); bad++; end
    idle(2);
    run_vec(2'b00, 1'b0, 8'h7F, 28'h1000000, 1'b0, 23'd0, r, lat);
    $display("cancel: s=%h", r);
    total++;
    if (r !== 32'h3E800000) begin $display("FAIL cancel_quarter s=%h want=3E800000", r); bad++; end
    idle(2);
    run_vec(2'b00, 1'b0, 8'h7F, 28'h0000000, 1'b0, 23'd0, r, lat);
    $display("zero: s=%h", r);
    total++;
    if (r !== 32'h00000000) begin $display("FAIL cancel_zero s=%h want=00000000", r); bad++; end
    idle(2);
  endtask

  task automatic test_rounding;
    logic [1:0]  rm_t  [6] = '{2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b01};
    logic        sg_t  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0]  ex_t  [6] = '{8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h02};
    logic [27:0] fr_t  [6] = '{28'h4000007, 28'h4000007, 28'h4000004, 28'h400000C,
                               28'h7FFFFFC, 28'h0800000};
    logic [31:0] exp_t [6] = '{32'h3F800001, 32'h3F800000, 32'h3F800000, 32'h3F800002,
                               32'h40000000, 32'h80200000};
    logic [31:0] r;
    int lat;
    for (int i = 0; i < 6; i++) begin
      run_vec(rm_t[i], sg_t[i], ex_t[i], fr_t[i], 1'b0, 23'd0, r, lat);
      $display("round[%0d]: rm=%b frac=%h s=%h", i, rm_t[i], fr_t[i], r);
      total++;
      if (r !== exp_t[i]) begin $display("FAIL round_%0d s=%h want=%h", i, r, exp_t[i]); bad++; end
      idle(1);
    end
  endtask

  task automatic test_overflow;
    logic [1:0]  rm_t  [4] = '{2'b00, 2'b11, 2'b10, 2'b01};
    logic        sg_t  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] exp_t [4] = '{32'h7F800000, 32'h7F7FFFFF, 32'hFF7FFFFF, 32'hFF800000};
    logic [31:0] r;
    int lat;
    for (int i = 0; i < 4; i++) begin
      run_vec(rm_t[i], sg_t[i], 8'hFE, 28'h8000000, 1'b0, 23'd0, r, lat);
      $display("overflow[%0d]: rm=%b sign=%b s=%h", i, rm_t[i], sg_t[i], r);
      total++;
      if (r !== exp_t[i]) begin $display("FAIL overflow_%0d s=%h want=%h", i, r, exp_t[i]); bad++; end
      idle(1);
    end
  endtask

  task automatic test_bypass;
    logic [31:0] r;
    int lat;
    run_vec(2'b00, 1'b0, 8'h7F, 28'h8000000, 1'b1, 23'h400000, r, lat);
    $display("bypass: s=%h", r);
    total++;
    if (r !== 32'h7FC00000) begin $display("FAIL bypass s=%h want=7FC00000", r); bad++; end
    idle(2);
  endtask

  task automatic test_back_to_back;
    logic [27:0] fr_t  [4] = '{28'h4000000, 28'h8000000, 28'h1000000, 28'h4000007};
    logic [31:0] exp_t [4] = '{32'h3F800000, 32'h40000000, 32'h3E800000, 32'h3F800001};
    int sent = 0, got = 0, stalls = 0;
    logic acc, tk;
    fif.c_rm = 2'b00; fif.c_sign = 1'b0; fif.c_exp = 8'h7F;
    fif.c_inf_nan = 1'b0; fif.c_inf_nan_frac = 23'd0;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      fif.out_ready = (cyc >= 5);
      fif.in_valid  = (sent < 4);
      if (sent < 4) fif.c_frac = fr_t[sent];
      #1;
      acc = fif.in_valid && fif.in_ready;
      tk  = fif.out_valid && fif.out_ready;
      if (fif.out_valid === 1'b1 && fif.out_ready === 1'b0) begin
        stalls++;
        total++;
        if (fif.in_ready !== 1'b0) begin $display("FAIL stall_in_ready got=%b want=0", fif.in_ready); bad++; end
        total++;
        if (fif.s !== exp_t[got]) begin $display("FAIL stall_hold s=%h want=%h", fif.s, exp_t[got]); bad++; end
      end
      if (tk) begin
        $display("stream out[%0d]: s=%h", got, fif.s);
        total++;
        if (fif.s !== exp_t[got]) begin $display("FAIL stream_%0d s=%h want=%h", got, fif.s, exp_t[got]); bad++; end
        got++;
      end
      if (acc) sent++;
      @(posedge clk); #1;
    end
    fif.in_valid = 1'b0;
    total++;
    if (got != 4) begin $display("FAIL stream_count got=%0d want=4", got); bad++; end
    total++;
    if (stalls != 3) begin $display("FAIL stall_cycles got=%0d want=3", stalls); bad++; end
    idle(2);
  endtask

  task automatic test_reset_midstream;
    int stale = 0;
    fif.c_rm = 2'b00; fif.c_sign = 1'b0; fif.c_exp = 8'h7F; fif.c_frac = 28'h8000000;
    fif.c_inf_nan = 1'b0; fif.c_inf_nan_frac = 23'd0;
    fif.out_ready = 1'b1;
    fif.in_valid  = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    clrn = 1'b0;
    fif.in_valid = 1'b0;
    @(posedge clk); #1;
    clrn = 1'b1;
    $display("midstream reset: out_valid=%b s=%h in_ready=%b", fif.out_valid, fif.s, fif.in_ready);
    total++;
    if (fif.out_valid !== 1'b0) begin $display("FAIL rst_mid_out_valid got=%b want=0", fif.out_valid); bad++; end
    total++;
    if (fif.s !== 32'h0) begin $display("FAIL rst_mid_s got=%h want=00000000", fif.s); bad++; end
    total++;
    if (fif.in_ready !== 1'b1) begin $display("FAIL rst_mid_in_ready got=%b want=1", fif.in_ready); bad++; end
    repeat (5) begin
      @(posedge clk); #1;
      if (fif.out_valid !== 1'b0) stale++;
    end
    total++;
    if (stale != 0) begin $display("FAIL rst_mid_stale got=%0d want=0", stale); bad++; end
  endtask

  initial begin
    clrn = 1'b0;
    fif.in_valid = 1'b0; fif.out_ready = 1'b1;
    fif.c_rm = 2'b00; fif.c_sign = 1'b0; fif.c_exp = 8'h00; fif.c_frac = 28'd0;
    fif.c_inf_nan = 1'b0; fif.c_inf_nan_frac = 23'd0;
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    clrn = 1'b1;
    idle(1);
    test_basic;
    test_rounding;
    test_overflow;
    test_bypass;
    test_back_to_back;
    test_reset_midstream;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/float_adder_pipe_norm.md
Name: float_adder_pipe_norm

Overview:
- Final stage of the pipelined FP adder. Takes the raw sum/difference from the calculation stage and produces a packed IEEE-754 single-precision result.
- Stage N1 normalizes: carry right-shift, leading-zero left-shift, denormal clamp.
- Stage N2 rounds under one of four rounding modes, handles overflow and Inf/NaN bypass, and packs the result.
- Two registered stages; valid/ready handshake with a global stall toward the FPU writeback.

Parameters:
- None. The format is fixed at binary32.

Ports:
- clk  in  1  clock; rising edge.
- clrn  in  1  synchronous active-low reset.
- in_valid  in  1  calculation-stage result valid.
- in_ready  out  1  block accepts input this cycle.
- c_rm  in  2  rounding mode: 00 nearest-even, 01 toward -inf, 10 toward +inf, 11 toward zero.
- c_sign  in  1  result sign.
- c_exp  in  8  biased exponent of the larger operand.
- c_frac  in  28  [27] carry, [26:3] 24-bit mantissa including hidden bit, [2:0] guard/round/sticky.
- c_inf_nan  in  1  Inf/NaN bypass.
- c_inf_nan_frac  in  23  fraction used on bypass.
- out_valid  out  1  s valid.
- out_ready  in  1  consumer accepts s.
- s  out  32  packed result.

Behaviour:
- Reset: when clrn=0 at a posedge, n1_valid=0, out_valid=0, s=0 and all stage registers are cleared. Any in-flight data is dropped. in_ready becomes 1 the next cycle.
- Stall: stall = out_valid & ~out_ready. in_ready = ~stall (combinational).
  - When not stalled, both stages advance every cycle.
  - Input is captured on in_valid & in_ready.
  - There are no bubbles-collapse rules.
- Latency: 2 edges. Input accepted at edge t produces s/out_valid after edge t+1, provided no stall. Throughput is 1/cycle.
- Ordering is preserved. Under stall, s and out_valid hold stable.
- N1 normalization, on fields e = c_exp and f = c_frac:
  - f[27]=1: f >>= 1, with the shifted-out bit ORed into sticky; e = e+1.
  - else f[26]=1: no shift; if e==0 then e=1.
  - else f==0: zero result, e=0, sign = c_sign.
  - else e==0: no shift (denormal).
  - else z = leading zeros of f[26:0]:
    - if e>z: f <<= z; e -= z.
    - otherwise: f <<= e-1; e = 0.
  - Left shifts fill with zeros. e is carried internally as 9 bits.
- N2 rounding, with mantissa m = f[26:3] and G, R, S = f[2:0]:
  - Increment when:
    - rm 00: G & (R|S|m[0]).
    - rm 01: sign & (G|R|S).
    - rm 10: ~sign & (G|R|S).
    - rm 11: never.
  - If the incremented value carries out of 24 bits: m = 0x800000, e+1.
  - If e==0 and rounded m[23]=1: e = 1 (denormal rounds up to normal).
- Overflow (e>=255 after N1 or after rounding):
  - rm 00: ±Inf.
  - rm 01: sign ? -Inf : +MAX.
  - rm 10: sign ? -MAX : +Inf.
  - rm 11: ±MAX.
  - MAX = exp 0xFE, frac 0x7FFFFF.
- Bypass: c_inf_nan=1 gives s = {c_sign, 8'hFF, c_inf_nan_frac}. Normalization and rounding results are ignored.
- Packing: s = {sign, e[7:0], m[22:0]}.

Optional Feature:
- FLOAT_NORM_FLAGS_EN defined: adds output s_flags[2:0] = {overflow, underflow, inexact}, registered alongside s, reset 0.
  - inexact = G|R|S after N1, or overflow.
  - underflow = result denormal or zero and inexact.
  - Flags are 0 on bypass.
- Not defined: the port and its logic are absent. s is identical in both builds.

Test Plan:
- 1.0+1.0: exp 0x7F, c_frac 0x8000000, rm 00 -> s 0x40000000, two cycles after acceptance.
- Cancellation: exp 0x7F, c_frac 0x1000000 -> s 0x3E800000 (0.25). c_frac 0 -> s 0x00000000.
- Rounding, exp 0x7F:
  - c_frac 0x4000007: rm 00 -> 0x3F800001; rm 11 -> 0x3F800000.
  - Ties: c_frac 0x4000004 -> 0x3F800000; c_frac 0x400000C -> 0x3F800002.
- Overflow: exp 0xFE, c_frac 0x8000000, sign 0: rm 00 -> 0x7F800000; rm 11 -> 0x7F7FFFFF. Sign 1, rm 10 -> 0xFF7FFFFF.
- Bypass: c_inf_nan=1, sign 0, c_inf_nan_frac 0x400000 -> 0x7FC00000.
- Handshake/reset:
  - Stream 4 inputs with out_ready low for 3 cycles: in_ready drops, s holds, all 4 results emerge in order with none lost.
  - clrn low mid-stream: out_valid=0 next cycle and no stale results appear afterwards.
